// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, receiver state encoding and a saturating counter helper
// used by the sync receiver and its edge detectors.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_D_NOM         = 640;
  localparam int H_F_NOM         = 16;
  localparam int H_R_NOM         = 96;
  localparam int H_B_NOM         = 48;
  localparam int V_D_NOM         = 480;
  localparam int V_F_NOM         = 10;
  localparam int V_R_NOM         = 2;
  localparam int V_B_NOM         = 33;
  localparam int LOCK_FRAMES_NOM = 2;

  localparam int H_TOTAL  = H_D_NOM + H_F_NOM + H_B_NOM + H_R_NOM;
  localparam int HS_START = H_D_NOM + H_F_NOM;
  localparam int V_TOTAL  = V_D_NOM + V_F_NOM + V_B_NOM + V_R_NOM;
  localparam int VS_START = V_D_NOM + V_F_NOM;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == {COORD_W{1'b1}}) ? v : v + {{(COORD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync history register and fall/rise detector; the history only advances on pixel ticks
// and idles high so a line that is already low after reset reads as a fall.
module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_p_tick,
  input  logic i_sync,
  output logic o_fall,
  output logic o_rise
);

  logic r_hist;

  // previous pixel-tick sample of the sync line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= 1'b1;
    end else if (i_p_tick) begin
      r_hist <= i_sync;
    end
  end

  assign o_fall = i_p_tick & r_hist & ~i_sync;
  assign o_rise = i_p_tick & ~r_hist & i_sync;

endmodule

// File: rtl/vga_sync_receptor.sv
// VGA sync receiver: locks onto the incoming hsync/vsync frame structure, regenerates
// pixel coordinates and flags lines or frames whose timing departs from nominal.
module vga_sync_receptor
  import vga_timing_pkg::*;
#(
  parameter int H_D         = H_D_NOM,
  parameter int H_F         = H_F_NOM,
  parameter int H_R         = H_R_NOM,
  parameter int H_B         = H_B_NOM,
  parameter int V_D         = V_D_NOM,
  parameter int V_F         = V_F_NOM,
  parameter int V_R         = V_R_NOM,
  parameter int V_B         = V_B_NOM,
  parameter int LOCK_FRAMES = LOCK_FRAMES_NOM
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               p_tick,
  input  logic               sincro_horiz,
  input  logic               sincro_vert,
  output logic [COORD_W-1:0] pixel_X_rx,
  output logic [COORD_W-1:0] pixel_Y_rx,
  output logic               video_on_rx,
  output logic               locked,
  output logic               h_err,
  output logic               v_err,
  output logic               frame_tick,
  output logic [7:0]         err_count
);

  localparam logic [COORD_W-1:0] L_HT_LAST  = COORD_W'(H_D + H_F + H_R + H_B - 1);
  localparam logic [COORD_W-1:0] L_HS_START = COORD_W'(H_D + H_F);
  localparam logic [COORD_W-1:0] L_VT_LAST  = COORD_W'(V_D + V_F + V_R + V_B - 1);
  localparam logic [COORD_W-1:0] L_VS_START = COORD_W'(V_D + V_F);
  localparam logic [COORD_W-1:0] L_H_D      = COORD_W'(H_D);
  localparam logic [COORD_W-1:0] L_V_D      = COORD_W'(V_D);
  localparam logic [COORD_W-1:0] L_H_R      = COORD_W'(H_R);
  localparam logic [COORD_W-1:0] L_V_R      = COORD_W'(V_R);
  localparam logic [COORD_W:0]   L_VT       = (COORD_W+1)'(V_D + V_F + V_R + V_B);
  localparam logic [3:0]         L_GOOD_LAST = 4'(LOCK_FRAMES - 1);

  logic w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
  logic w_x_wrap, w_h_raw, w_v_raw, w_h_err, w_v_err;
  logic [COORD_W-1:0] w_x_nxt, w_y_nxt, w_y_step;
  logic [COORD_W:0]   w_v_per_now;
  logic [8:0]         w_err_sum;
  logic [7:0]         w_err_nxt;
  rx_state_e          w_state_nxt;
  logic [3:0]         w_good_nxt;

  rx_state_e          r_state;
  logic [3:0]         r_good;
  logic [COORD_W-1:0] r_x, r_y, r_h_per, r_h_low, r_v_per, r_v_low;
  logic               r_locked, r_video_on, r_h_err, r_v_err, r_frame_tick;
  logic [7:0]         r_err_count;

  vga_sync_edge u_hs_edge (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_p_tick(p_tick), .i_sync(sincro_horiz),
    .o_fall(w_hs_fall), .o_rise(w_hs_rise)
  );

  vga_sync_edge u_vs_edge (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_p_tick(p_tick), .i_sync(sincro_vert),
    .o_fall(w_vs_fall), .o_rise(w_vs_rise)
  );

  assign w_x_wrap = p_tick & ~w_hs_fall & (r_x == L_HT_LAST);
  assign w_x_nxt  = w_hs_fall ? L_HS_START : ((r_x == L_HT_LAST) ? '0 : r_x + 1'b1);
  assign w_y_step = (r_y == L_VT_LAST) ? '0 : r_y + 1'b1;
  assign w_y_nxt  = w_vs_fall ? L_VS_START : (w_x_wrap ? w_y_step : r_y);

  // the wrap landing on the vsync fall itself closes the frame, so it is counted here
  assign w_v_per_now = {1'b0, r_v_per} + {{COORD_W{1'b0}}, w_x_wrap};

  assign w_h_raw = (w_hs_fall & (r_h_per != L_HT_LAST))
                 | (p_tick & ~w_hs_fall & (r_h_per == L_HT_LAST))
                 | (w_hs_rise & (r_h_low != L_H_R));
  assign w_v_raw = (w_vs_fall & (w_v_per_now != L_VT))
                 | (w_vs_rise & (r_v_low != L_V_R));
  assign w_h_err = w_h_raw & (r_state != SEARCH);
  assign w_v_err = w_v_raw & (r_state != SEARCH);

  assign w_err_sum = {1'b0, r_err_count} + {8'd0, w_h_err} + {8'd0, w_v_err};
  assign w_err_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  // lock state machine: next state and clean-frame counter
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 4'd0;
        end else begin
          w_state_nxt = SEARCH;
        end
      end
      ACQUIRE: begin
        if (w_h_err || w_v_err) begin
          w_state_nxt = SEARCH;
        end else if (w_vs_fall) begin
          if (r_good == L_GOOD_LAST) begin
            w_state_nxt = LOCKED;
          end else begin
            w_good_nxt = r_good + 4'd1;
          end
        end else begin
          w_state_nxt = ACQUIRE;
        end
      end
      LOCKED: begin
        if (w_h_err || w_v_err) begin
          w_state_nxt = SEARCH;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = 4'd0;
      end
    endcase
  end

  // coordinate, period counters and lock state; all advance only on pixel ticks
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= SEARCH;
      r_good     <= 4'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_h_per    <= '0;
      r_h_low    <= '0;
      r_v_per    <= '0;
      r_v_low    <= '0;
      r_locked   <= 1'b0;
      r_video_on <= 1'b0;
    end else if (p_tick) begin
      r_state    <= w_state_nxt;
      r_good     <= w_good_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_h_per    <= w_hs_fall ? '0 : sat_inc(r_h_per);
      r_h_low    <= w_hs_fall ? {{(COORD_W-1){1'b0}}, 1'b1}
                              : (~sincro_horiz ? sat_inc(r_h_low) : r_h_low);
      r_v_per    <= w_vs_fall ? '0 : (w_x_wrap ? sat_inc(r_v_per) : r_v_per);
      r_v_low    <= w_vs_fall ? {{(COORD_W-1){1'b0}}, w_x_wrap}
                              : ((~sincro_vert & w_x_wrap) ? sat_inc(r_v_low) : r_v_low);
      r_locked   <= (w_state_nxt == LOCKED);
      r_video_on <= (w_state_nxt == LOCKED) && (w_x_nxt < L_H_D) && (w_y_nxt < L_V_D);
    end
  end

  // single-cycle event pulses and the saturating error tally
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_h_err      <= 1'b0;
      r_v_err      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_err_count  <= 8'd0;
    end else begin
      r_h_err      <= w_h_err;
      r_v_err      <= w_v_err;
      r_frame_tick <= w_vs_fall & (r_state == LOCKED);
      r_err_count  <= w_err_nxt;
    end
  end

  assign pixel_X_rx  = r_x;
  assign pixel_Y_rx  = r_y;
  assign video_on_rx = r_video_on;
  assign locked      = r_locked;
  assign h_err       = r_h_err;
  assign v_err       = r_v_err;
  assign frame_tick  = r_frame_tick;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_sync_receptor.sv
// Randomised bench for vga_sync_receptor on a reduced timing grid, checked tick by tick
// against a behavioural model derived from the receiver's timing rules.
module tb_vga_sync_receptor;

  localparam int HD = 16, HF = 2, HR = 4, HB = 3;
  localparam int VD = 6,  VF = 2, VR = 2, VB = 3;
  localparam int LF = 2;
  localparam int HT = HD + HF + HR + HB;
  localparam int HS = HD + HF;
  localparam int VT = VD + VF + VR + VB;
  localparam int VS = VD + VF;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       p_tick = 1'b0;
  logic       sincro_horiz = 1'b1;
  logic       sincro_vert = 1'b1;
  logic [9:0] pixel_X_rx, pixel_Y_rx;
  logic       video_on_rx, locked, h_err, v_err, frame_tick;
  logic [7:0] err_count;

  always #5 CLK = ~CLK;

  vga_sync_receptor #(
    .H_D(HD), .H_F(HF), .H_R(HR), .H_B(HB),
    .V_D(VD), .V_F(VF), .V_R(VR), .V_B(VB), .LOCK_FRAMES(LF)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .p_tick(p_tick),
    .sincro_horiz(sincro_horiz), .sincro_vert(sincro_vert),
    .pixel_X_rx(pixel_X_rx), .pixel_Y_rx(pixel_Y_rx), .video_on_rx(video_on_rx),
    .locked(locked), .h_err(h_err), .v_err(v_err), .frame_tick(frame_tick),
    .err_count(err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: tick index, last hsync fall, coordinates, frame bookkeeping
  int m_n, m_nf, m_base, m_x, m_y, m_vcnt, m_vlow, m_st, m_good, m_ecnt;
  bit m_hs_p, m_vs_p;
  bit ex_von, ex_lock, ex_herr, ex_verr, ex_ft;

  // generator position and perturbation controls
  int gx = 0, gy = 0;
  bit early_en = 1'b0, long_v = 1'b0, stuck_h = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (model tick %0d, t=%0t)", tag, obs, exp, m_n, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_nf = 0; m_base = 0; m_x = 0; m_y = 0;
    m_vcnt = 0; m_vlow = 0; m_st = 0; m_good = 0; m_ecnt = 0;
    m_hs_p = 1'b1; m_vs_p = 1'b1;
    ex_von = 0; ex_lock = 0; ex_herr = 0; ex_verr = 0; ex_ft = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hf, hr, vf, vr, wrap, he, ve;
    int hper, hlow;
    m_n++;
    hf = m_hs_p && !hs;  hr = !m_hs_p && hs;
    vf = m_vs_p && !vs;  vr = !m_vs_p && vs;
    hper = m_n - 1 - m_nf;  if (hper > 1023) hper = 1023;
    hlow = m_n - m_nf;      if (hlow > 1023) hlow = 1023;
    if (hf) begin
      m_nf = m_n;
      m_base = HS;
    end
    m_x  = (m_base + m_n - m_nf) % HT;
    wrap = !hf && (m_x == 0);
    he = hf ? (hper != HT - 1) : (hper == HT - 1);
    if (hr && hlow != HR) he = 1'b1;
    ve = (vf && (m_vcnt + int'(wrap)) != VT) || (vr && m_vlow != VR);
    if (m_st == 0) begin
      he = 1'b0;
      ve = 1'b0;
    end
    ex_ft = vf && (m_st == 2);
    case (m_st)
      0: if (vf) begin m_st = 1; m_good = 0; end
      1: if (he || ve) m_st = 0;
         else if (vf) begin
           if (m_good == LF - 1) m_st = 2;
           else m_good++;
         end
      default: if (he || ve) m_st = 0;
    endcase
    m_ecnt += int'(he) + int'(ve);
    if (m_ecnt > 255) m_ecnt = 255;
    m_y = vf ? VS : (wrap ? (m_y + 1) % VT : m_y);
    if (vf) m_vcnt = 0; else if (wrap) m_vcnt++;
    if (vf) m_vlow = int'(wrap); else if (!vs && wrap) m_vlow++;
    m_hs_p = hs;
    m_vs_p = vs;
    ex_herr = he;
    ex_verr = ve;
    ex_lock = (m_st == 2);
    ex_von  = ex_lock && (m_x < HD) && (m_y < VD);
  endtask

  task automatic check_all(input bit idle);
    check_eq("pixel_X_rx",  32'(pixel_X_rx),  32'(m_x));
    check_eq("pixel_Y_rx",  32'(pixel_Y_rx),  32'(m_y));
    check_eq("video_on_rx", 32'(video_on_rx), 32'(ex_von));
    check_eq("locked",      32'(locked),      32'(ex_lock));
    check_eq("err_count",   32'(err_count),   32'(m_ecnt));
    check_eq("h_err",       32'(h_err),       idle ? 32'd0 : 32'(ex_herr));
    check_eq("v_err",       32'(v_err),       idle ? 32'd0 : 32'(ex_verr));
    check_eq("frame_tick",  32'(frame_tick),  idle ? 32'd0 : 32'(ex_ft));
  endtask

  task automatic do_tick(input bit hs, input bit vs);
    int gap;
    @(negedge CLK);
    sincro_horiz = hs;
    sincro_vert  = vs;
    p_tick       = 1'b1;
    @(negedge CLK);
    p_tick = 1'b0;
    model_step(hs, vs);
    check_all(1'b0);
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++) begin
      @(negedge CLK);
      check_all(1'b1);
    end
  endtask

  task automatic gen_step();
    bit hs, vs;
    hs = !(gx >= HS && gx < HS + HR);
    if (early_en && gx == HS - 1) hs = 1'b0;
    if (stuck_h) hs = 1'b1;
    vs = !(gy >= VS && gy < VS + VR + (long_v ? 1 : 0));
    do_tick(hs, vs);
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic run_ticks(input int k);
    for (int i = 0; i < k; i++) gen_step();
  endtask

  task automatic run_to_line_start(input int line);
    for (int k = 0; k < HT * VT && !(gx == 0 && gy == line); k++) gen_step();
  endtask

  initial begin
    model_reset();
    #2 RESET_N = 1'b0;
    #20 check_all(1'b1);
    #78 RESET_N = 1'b1;

    // clean frames: lock on the third vsync fall, then stay locked
    run_ticks(6 * HT * VT);
    check_eq("locked_after_acquire", 32'(locked), 32'd1);

    // one hsync falling a tick early
    run_to_line_start($urandom_range(0, VT - 1));
    early_en = 1'b1;
    run_ticks(HT);
    early_en = 1'b0;
    check_eq("early_hsync_errcnt", 32'(err_count), 32'd1);
    check_eq("early_hsync_unlock", 32'(locked), 32'd0);
    run_ticks(4 * HT * VT);
    check_eq("relock_after_hsync", 32'(locked), 32'd1);

    // a three-line vsync pulse
    run_to_line_start(0);
    long_v = 1'b1;
    run_ticks(HT * VT);
    long_v = 1'b0;
    check_eq("long_vsync_errcnt", 32'(err_count), 32'd2);
    run_ticks(4 * HT * VT);
    check_eq("relock_after_vsync", 32'(locked), 32'd1);

    // hsync stuck high: a single missed-line error
    run_to_line_start($urandom_range(0, VT - 1));
    stuck_h = 1'b1;
    run_ticks(3 * HT);
    stuck_h = 1'b0;
    check_eq("stuck_hsync_errcnt", 32'(err_count), 32'd3);
    run_ticks(4 * HT * VT);
    check_eq("relock_after_stuck", 32'(locked), 32'd1);

    // pixel enable idle while the sync lines toggle
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      sincro_horiz = 1'($urandom);
      sincro_vert  = 1'($urandom);
      check_all(1'b1);
    end

    // error storm on rapid vsync toggling drives the tally into saturation
    for (int i = 0; i < 700; i++) do_tick(1'b1, 1'(i % 2));
    check_eq("err_count_saturated", 32'(err_count), 32'd255);
    run_ticks(4 * HT * VT);
    check_eq("relock_after_storm", 32'(locked), 32'd1);

    // asynchronous reset in the middle of a frame
    run_ticks($urandom_range(HT, 4 * HT));
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1 model_reset();
    check_all(1'b1);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    check_all(1'b1);
    run_ticks(4 * HT * VT);
    check_eq("relock_after_reset", 32'(locked), 32'd1);
    check_eq("errcnt_after_reset", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_receptor.md
Name: vga_sync_receptor

Overview:
- Receive end of the VGA timing interface driven by Sincronizador_P2.
- Samples sincro_horiz, sincro_vert and p_tick, locks onto the 640x480 frame structure, and regenerates pixel_X/pixel_Y/video_on locally.
- Checks every line and frame against nominal timing and reports violations.
- Used as an on-chip timing monitor and as the coordinate source for downstream RTC overlay logic that only sees sync lines.

Parameters:
H_D, 640, visible pixels per line
H_F, 16, horizontal front porch (pixels)
H_R, 96, hsync pulse width (pixels)
H_B, 48, horizontal back porch (pixels)
V_D, 480, visible lines
V_F, 10, vertical front porch (lines)
V_R, 2, vsync pulse width (lines)
V_B, 33, vertical back porch (lines)
LOCK_FRAMES, 2, consecutive clean frames required to lock (1..15)

Ports:
CLK  in  1  system clock, same domain as the sync generator
RESET_N  in  1  asynchronous, active-low reset
p_tick  in  1  pixel enable, one CLK wide; all sampling happens only on p_tick
sincro_horiz  in  1  hsync, active low
sincro_vert  in  1  vsync, active low
pixel_X_rx  out  10  recovered column, 0..H_TOTAL-1
pixel_Y_rx  out  10  recovered row, 0..V_TOTAL-1
video_on_rx  out  1  locked && pixel_X_rx<H_D && pixel_Y_rx<V_D
locked  out  1  high only in state LOCKED
h_err  out  1  one-CLK pulse on a horizontal timing violation
v_err  out  1  one-CLK pulse on a vertical timing violation
frame_tick  out  1  one-CLK pulse on a vsync falling edge while locked
err_count  out  8  saturating count of h_err + v_err pulses

Behaviour:
- Derived constants: H_TOTAL=H_D+H_F+H_B+H_R=800, HS_START=H_D+H_F=656, V_TOTAL=525, VS_START=V_D+V_F=490.
- Reset (async, RESET_N=0): all outputs 0. State SEARCH. Sync history registers set to 1 (idle high). All counters 0.
- Edges: hs_fall, hs_rise, vs_fall and vs_rise compare the current sample with the previous p_tick sample. No synchronizer is used; the inputs are registered in the CLK domain.
- All state updates occur only on CLK edges with p_tick=1. Outputs are registered and reflect the sample taken at that p_tick (1 CLK latency).
- x counter:
  - On hs_fall: x <= HS_START.
  - Otherwise x <= (x==H_TOTAL-1) ? 0 : x+1.
- y counter:
  - On vs_fall: y <= VS_START. This has priority over a simultaneous x wrap.
  - Otherwise, on x wrap: y <= (y==V_TOTAL-1) ? 0 : y+1.
- h_per: ticks since the last hs_fall, saturating at 1023.
  - At hs_fall: error if h_per != H_TOTAL-1; then h_per <= 0.
  - If h_per reaches H_TOTAL with no fall (missed hsync): error once; h_per saturates with no further pulses until the next fall.
- h_low: ticks with hsync low. At hs_rise: error if h_low != H_R.
- v_per: count of x wraps since the last vs_fall. At vs_fall: error if v_per != V_TOTAL.
- v_low: count of x wraps with vsync low. At vs_rise: error if v_low != V_R.
- Error reporting:
  - Checks are suppressed in SEARCH.
  - h_err and v_err may pulse in the same cycle; err_count then adds 2, saturating at 255.
- FSM:
  - SEARCH: on vs_fall -> ACQUIRE, good <= 0. All period counters restart.
  - ACQUIRE: any error -> SEARCH. On a clean vs_fall, good++; when good==LOCK_FRAMES-1 at that vs_fall -> LOCKED.
  - LOCKED: any error -> SEARCH, locked drops on the next CLK. Each vs_fall pulses frame_tick.
- Reset mid-operation returns immediately to the reset state. err_count clears only on reset.

Decomposition:
- Package vga_timing_pkg:
  - Timing constants and derived totals (H_TOTAL, HS_START, V_TOTAL, VS_START).
  - State enum {SEARCH, ACQUIRE, LOCKED}.
  - Width constant for the 10-bit coordinate.
- One sub-module, vga_sync_edge: history register plus fall/rise detect gated by p_tick, with reset value 1. Instantiated once for hsync and once for vsync.

Test Plan:
- Generator driving the block (CLK 10 ns, p_tick every 4 CLK), reset released at 100 ns -> locked rises at the third vs_fall. From then on pixel_X_rx==pixel_X, pixel_Y_rx==pixel_Y and video_on_rx==video_on every p_tick. No errors over 3 further frames.
- While locked, one line has hsync falling 799 ticks after the previous fall -> one h_err pulse, locked=0, err_count=1. Relock after the required frames.
- While locked, a vsync pulse of 3 lines -> v_err at vs_rise, state SEARCH, err_count increments by 1.
- hsync held high while locked -> exactly one h_err, 800 p_ticks after the last fall.
- 300 forced errors -> err_count stops at 255. Assert RESET_N=0 mid-frame -> all outputs 0 asynchronously; after release, state SEARCH.
- p_tick held low for 1000 CLK with sync toggling -> no counter, edge or error activity.
